div_seq_r2: RTL and testbench
=============================

DIV_SEQ_R2 -- requirements
Module: div_seq_r2

Interface
REQ-001 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 in_valid  input  1  operand pair valid.
REQ-005 in_ready  output  1  block can accept operands; high only in IDLE.
REQ-006 dividend  input  16  numerator, sampled on the input handshake.
REQ-007 divisor  input  16  denominator, sampled on the input handshake.
REQ-008 out_valid  output  1  result valid; high only in DONE.
REQ-009 out_ready  input  1  consumer accepts result.
REQ-010 quotient  output  16  registered quotient.
REQ-011 remainder  output  16  registered remainder.
REQ-012 div_by_zero  output  1  divisor was zero.
REQ-013 overflow  output  1  signed -32768 / -1 case.

Function
REQ-014 The block SHALL use the states IDLE, CALC, FIX and DONE; the reset state SHALL be IDLE.
REQ-015 The input handshake SHALL be in_valid && in_ready at a rising edge; operands SHALL be latched on that edge.
REQ-016 IDLE->CALC on the handshake when divisor != 0; IDLE->DONE on the handshake when divisor == 0.
REQ-017 On entry to CALC, operand magnitudes SHALL be taken: two's-complement negate when the sign bit is set. -32768 SHALL yield magnitude 16'h8000.
REQ-018 CALC SHALL perform radix-2 restoring division, one quotient bit per cycle, MSB first, for exactly 16 cycles, using a 17-bit partial remainder, tracked by a 4-bit counter. CALC->FIX after the 16th iteration.
REQ-019 FIX (1 cycle) SHALL negate the quotient when the operand signs differ and negate the remainder when the dividend is negative. Quotient SHALL truncate toward zero; the remainder SHALL take the dividend's sign. FIX->DONE.
REQ-020 Latency SHALL be 18 cycles from the accepting edge to out_valid high, and 1 cycle for divide-by-zero.
REQ-021 Divide-by-zero SHALL give quotient=16'hFFFF, remainder=dividend, div_by_zero=1.
REQ-022 -32768 / -1 SHALL give quotient=16'h8000, remainder=0, overflow=1 through the normal CALC/FIX path.
REQ-023 In DONE, quotient, remainder, div_by_zero and overflow SHALL be held stable while out_ready is low.
REQ-024 DONE->IDLE on out_valid && out_ready. in_ready SHALL go high the following cycle; there SHALL be no same-cycle output/input overlap.
REQ-025 in_valid SHALL be ignored outside IDLE. Operand changes after acceptance SHALL NOT affect the result.
REQ-026 Flags SHALL update only on entry to DONE; each result SHALL clear the previous result's flags.

Reset
REQ-027 When rst_n is low: state=IDLE, in_ready=1, out_valid=0, quotient=0, remainder=0, div_by_zero=0, overflow=0, counter=0.
REQ-028 Reset asserted in CALC, FIX or DONE SHALL abort the operation immediately, with no result emitted after release.

Configuration
REQ-029 Macro DIV_SIGNED_EN defined: operands and results SHALL be signed two's complement per REQ-017/019/022.
REQ-030 Macro DIV_SIGNED_EN undefined: operands SHALL be unsigned, there SHALL be no negation, overflow SHALL be tied to 0, and FIX SHALL remain one pass-through cycle so latency is unchanged.

Verification
REQ-031 With DIV_SIGNED_EN: 100 / 7 -> quotient 16'h000E, remainder 16'h0002, out_valid exactly 18 cycles after acceptance.
REQ-032 With DIV_SIGNED_EN: -100 / 7 -> quotient 16'hFFF2, remainder 16'hFFFE; 100 / -7 -> 16'hFFF2, 16'h0002.
REQ-033 1234 / 0 -> quotient 16'hFFFF, remainder 16'h04D2, div_by_zero=1, out_valid 1 cycle after acceptance.
REQ-034 With DIV_SIGNED_EN: -32768 / -1 -> quotient 16'h8000, remainder 0, overflow=1. Without the macro: 16'h8000 / 16'hFFFF -> quotient 0, remainder 16'h8000, overflow=0.
REQ-035 out_ready held low for 5 cycles in DONE -> outputs stable and in_ready=0 throughout. A following back-to-back 50 / 5 -> quotient 10, remainder 0, flags clear.
REQ-036 rst_n pulsed low in CALC iteration 8 -> all outputs at reset values, no out_valid afterwards. The next 9 / 2 -> quotient 4, remainder 1.

Source files
------------

// File: rtl/div_seq_r2.sv
// rtl/div_seq_r2.sv - sequential radix-2 restoring 16-bit divider with valid/ready handshakes
//
// Computes quotient and remainder of a 16-bit dividend by a 16-bit divisor.
// Each operation spends 16 cycles in CALC (one quotient bit per cycle, MSB first)
// and one cycle in FIX before the result is presented. Divide-by-zero skips
// straight to DONE.
//
// Optional feature macro: DIV_SIGNED_EN
//   defined   : operands/results are signed two's complement, quotient truncates
//               toward zero, remainder takes the dividend's sign, -32768/-1 flags
//               overflow.
//   undefined : operands are unsigned, no negation, overflow is always 0; FIX is
//               kept as a pass-through cycle so latency is identical.
//
// Ports:
//   clk          in   1   rising-edge clock
//   rst_n        in   1   asynchronous active-low reset
//   in_valid     in   1   operand pair valid
//   in_ready     out  1   operands can be accepted (IDLE only)
//   dividend     in   16  numerator, sampled on in_valid && in_ready
//   divisor      in   16  denominator, sampled on in_valid && in_ready
//   out_valid    out  1   result valid (DONE only)
//   out_ready    in   1   consumer accepts result
//   quotient     out  16  registered quotient
//   remainder    out  16  registered remainder
//   div_by_zero  out  1   divisor was zero
//   overflow     out  1   signed -32768 / -1

`timescale 1ns/1ps

module div_seq_r2 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] dividend,
    input  logic [15:0] divisor,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] quotient,
    output logic [15:0] remainder,
    output logic        div_by_zero,
    output logic        overflow
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t      state_q;
    logic [3:0]  cnt_q;
    logic [15:0] quo_q;         // dividend magnitude shifted out, quotient bits shifted in
    logic [15:0] dsr_q;         // divisor magnitude
    logic [16:0] rem_q;         // partial remainder
    logic        neg_quo_q;     // operand signs differ
    logic        neg_rem_q;     // dividend was negative
    logic        ovf_pend_q;    // overflow case detected at acceptance, published on entry to DONE

    logic        in_ready_q;
    logic        out_valid_q;
    logic [15:0] quotient_q;
    logic [15:0] remainder_q;
    logic        dbz_q;
    logic        ovf_q;

    // Operand conditioning at acceptance
    logic [15:0] dvd_mag;
    logic [15:0] dsr_mag;
    logic        dvd_neg;
    logic        dsr_neg;
    logic        ovf_in;

`ifdef DIV_SIGNED_EN
    // Two's-complement negation of 16'h8000 yields 16'h8000, which is exactly
    // the magnitude needed when it is read as unsigned.
    assign dvd_neg = dividend[15];
    assign dsr_neg = divisor[15];
    assign dvd_mag = dvd_neg ? (~dividend + 16'd1) : dividend;
    assign dsr_mag = dsr_neg ? (~divisor + 16'd1) : divisor;
    assign ovf_in  = (dividend == 16'h8000) && (divisor == 16'hFFFF);
`else
    assign dvd_neg = 1'b0;
    assign dsr_neg = 1'b0;
    assign dvd_mag = dividend;
    assign dsr_mag = divisor;
    assign ovf_in  = 1'b0;
`endif

    // One restoring iteration. The trial subtraction is one bit wider than the
    // partial remainder: in unsigned mode the shifted remainder can reach 17
    // significant bits, so bit 17 is the only reliable borrow indicator.
    logic [16:0] shift_d;
    logic [17:0] trial_d;
    logic [16:0] rem_d;
    logic [15:0] quo_d;

    assign shift_d = {rem_q[15:0], quo_q[15]};
    assign trial_d = {1'b0, shift_d} - {2'b00, dsr_q};

    always_comb begin
        rem_d = shift_d;
        quo_d = {quo_q[14:0], 1'b0};
        if (!trial_d[17]) begin
            rem_d = trial_d[16:0];
            quo_d = {quo_q[14:0], 1'b1};
        end
    end

    // Sign correction applied in FIX (pass-through when signs are not tracked)
    logic [15:0] quo_fix;
    logic [15:0] rem_fix;

    assign quo_fix = neg_quo_q ? (~quo_q + 16'd1) : quo_q;
    assign rem_fix = neg_rem_q ? (~rem_q[15:0] + 16'd1) : rem_q[15:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            quo_q       <= 16'd0;
            dsr_q       <= 16'd0;
            rem_q       <= 17'd0;
            neg_quo_q   <= 1'b0;
            neg_rem_q   <= 1'b0;
            ovf_pend_q  <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            quotient_q  <= 16'd0;
            remainder_q <= 16'd0;
            dbz_q       <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid && in_ready_q) begin
                        in_ready_q <= 1'b0;
                        if (divisor == 16'd0) begin
                            state_q     <= DONE;
                            out_valid_q <= 1'b1;
                            quotient_q  <= 16'hFFFF;
                            remainder_q <= dividend;
                            dbz_q       <= 1'b1;
                            ovf_q       <= 1'b0;
                        end else begin
                            state_q    <= CALC;
                            cnt_q      <= 4'd0;
                            quo_q      <= dvd_mag;
                            dsr_q      <= dsr_mag;
                            rem_q      <= 17'd0;
                            neg_quo_q  <= dvd_neg ^ dsr_neg;
                            neg_rem_q  <= dvd_neg;
                            ovf_pend_q <= ovf_in;
                        end
                    end
                end

                CALC: begin
                    rem_q <= rem_d;
                    quo_q <= quo_d;
                    cnt_q <= cnt_q + 4'd1;
                    if (cnt_q == 4'd15) begin
                        state_q <= FIX;
                    end
                end

                FIX: begin
                    state_q     <= DONE;
                    out_valid_q <= 1'b1;
                    quotient_q  <= quo_fix;
                    remainder_q <= rem_fix;
                    dbz_q       <= 1'b0;
                    ovf_q       <= ovf_pend_q;
                end

                DONE: begin
                    // Results stay frozen until the consumer takes them; in_ready
                    // only rises the cycle after the output handshake.
                    if (out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end

                default: begin
                    state_q     <= IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;
    assign overflow    = ovf_q;

endmodule

// File: tb/tb_div_seq_r2.sv
// tb/tb_div_seq_r2.sv - scoreboard bench for div_seq_r2 with randomized operands

`timescale 1ns/1ps

module tb_div_seq_r2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] dividend = 16'd0;
    logic [15:0] divisor = 16'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] quotient;
    logic [15:0] remainder;
    logic        div_by_zero;
    logic        overflow;

    div_seq_r2 dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] q;
        logic [15:0] r;
        logic        dbz;
        logic        ovf;
        int          acc;
        int          lat;
    } exp_t;

    exp_t sbq[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: plain language arithmetic on the operands.
    function automatic exp_t model(input logic [15:0] a, input logic [15:0] b);
        exp_t e;
`ifdef DIV_SIGNED_EN
        int sa;
        int sb;
        int qq;
        int rr;
`endif
        e.a = a;
        e.b = b;
        e.dbz = 1'b0;
        e.ovf = 1'b0;
        e.acc = 0;
        e.lat = (b == 16'd0) ? 1 : 18;
        if (b == 16'd0) begin
            e.q = 16'hFFFF;
            e.r = a;
            e.dbz = 1'b1;
        end else begin
`ifdef DIV_SIGNED_EN
            sa = $signed(a);
            sb = $signed(b);
            qq = sa / sb;
            rr = sa % sb;
            e.q = qq[15:0];
            e.r = rr[15:0];
            e.ovf = (sa == -32768) && (sb == -1);
`else
            e.q = a / b;
            e.r = a % b;
`endif
        end
        return e;
    endfunction

    // Monitor: captures each result when it first appears, checks it stays
    // stable while stalled, drives out_ready, and scores it on handshake.
    bit          mon_en = 1'b0;
    bit          seen = 1'b0;
    bit          stall_next = 1'b0;
    int          stall_left = 0;
    logic [15:0] cap_q;
    logic [15:0] cap_r;
    logic        cap_dbz;
    logic        cap_ovf;
    exp_t        mon_e;

    always @(negedge clk) begin
        if (mon_en && rst_n) begin
            if (out_valid) begin
                if (!seen) begin
                    if (sbq.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_out_valid actual=1 required=0 (t=%0t)", $time);
                    end else begin
                        check("latency", cyc - sbq[0].acc + 1, sbq[0].lat);
                    end
                    cap_q   = quotient;
                    cap_r   = remainder;
                    cap_dbz = div_by_zero;
                    cap_ovf = overflow;
                    seen    = 1'b1;
                    if (stall_next) begin
                        stall_left = 5;
                        stall_next = 1'b0;
                    end
                end else begin
                    check("hold_quotient", quotient, cap_q);
                    check("hold_remainder", remainder, cap_r);
                    check("hold_flags", {div_by_zero, overflow}, {cap_dbz, cap_ovf});
                end
                check("in_ready_low_in_done", in_ready, 1'b0);
                if (stall_left > 0) begin
                    out_ready  = 1'b0;
                    stall_left = stall_left - 1;
                end else begin
                    out_ready = ($urandom_range(0, 3) != 0);
                end
                if (out_ready) begin
                    if (sbq.size() > 0) begin
                        mon_e = sbq.pop_front();
                        check($sformatf("quotient %h/%h", mon_e.a, mon_e.b), quotient, mon_e.q);
                        check($sformatf("remainder %h/%h", mon_e.a, mon_e.b), remainder, mon_e.r);
                        check($sformatf("div_by_zero %h/%h", mon_e.a, mon_e.b), div_by_zero, mon_e.dbz);
                        check($sformatf("overflow %h/%h", mon_e.a, mon_e.b), overflow, mon_e.ovf);
                    end
                    seen = 1'b0;
                end
            end else begin
                seen = 1'b0;
                out_ready = $urandom_range(0, 1);
            end
        end
    end

    task automatic issue(input logic [15:0] a, input logic [15:0] b, input bit push, input bit stall);
        exp_t e;
        int   n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL in_ready_timeout actual=0 required=1 (t=%0t)", $time);
            return;
        end
        in_valid   = 1'b1;
        dividend   = a;
        divisor    = b;
        stall_next = stall;
        @(posedge clk);
        #1;
        if (push) begin
            e = model(a, b);
            e.acc = cyc;
            sbq.push_back(e);
        end
        // Scribble the operand bus after acceptance; keep in_valid up while
        // the block is known to be busy so it must be ignored.
        dividend = 16'($urandom);
        divisor  = 16'($urandom);
        in_valid = (b != 16'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        dividend = 16'($urandom);
        divisor  = 16'($urandom);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_in_ready"}, in_ready, 1'b1);
        check({tag, "_out_valid"}, out_valid, 1'b0);
        check({tag, "_quotient"}, quotient, 16'd0);
        check({tag, "_remainder"}, remainder, 16'd0);
        check({tag, "_div_by_zero"}, div_by_zero, 1'b0);
        check({tag, "_overflow"}, overflow, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int spurious;
        logic [15:0] ra;
        logic [15:0] rb;

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_values("reset");
        @(negedge clk);
        rst_n  = 1'b1;
        mon_en = 1'b1;

        // Directed cases
        issue(16'd100, 16'd7, 1, 0);
        issue(16'hFF9C, 16'd7, 1, 0);        // -100 / 7
        issue(16'd100, 16'hFFF9, 1, 0);      // 100 / -7
        issue(16'd1234, 16'd0, 1, 0);
        issue(16'h8000, 16'hFFFF, 1, 0);
        issue(16'h8000, 16'd1, 1, 0);
        issue(16'hFFFF, 16'd1, 1, 0);
        issue(16'd3, 16'hFFFF, 1, 0);
        issue(16'h8000, 16'hFFFF, 1, 1);     // stalled 5 cycles in DONE
        issue(16'd50, 16'd5, 1, 0);
        issue(16'd7, 16'd0, 1, 1);           // stalled divide-by-zero
        issue(16'd50, 16'd5, 1, 0);

        // Reset during CALC: no result may ever come out for this operation
        issue(16'd1000, 16'd3, 0, 0);
        repeat (6) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_values("abort");
        repeat (2) @(posedge clk);
        #1;
        check_reset_values("abort_hold");
        @(negedge clk);
        rst_n = 1'b1;
        spurious = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) spurious++;
        end
        check("no_result_after_abort", spurious, 0);
        issue(16'd9, 16'd2, 1, 0);

        // Randomized operands, biased toward the corner divisors/dividends
        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 7))
                0: rb = 16'd0;
                1: rb = 16'hFFFF;
                2: rb = 16'd1;
                3: rb = 16'($urandom_range(1, 15));
                default: rb = 16'($urandom);
            endcase
            case ($urandom_range(0, 7))
                0: ra = 16'h8000;
                1: ra = 16'd0;
                default: ra = 16'($urandom);
            endcase
            issue(ra, rb, 1, ($urandom_range(0, 9) == 0));
        end

        n = 0;
        while (sbq.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("scoreboard_drained", sbq.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
